// File: rtl/multiplier_arbiter_pkg.sv
// Shared helpers for the multiplier arbiter slice.
package multiplier_arbiter_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int res_width(input int w1, input int w2);
    return w1 + w2;
  endfunction

endpackage

// File: rtl/multiplier.sv
// Combinational unsigned multiplier shared by the arbiter.
module multiplier #(
  parameter int    DATA_WIDTH_1 = 8,
  parameter int    DATA_WIDTH_2 = 8,
  parameter string ARCHITECTURE = "BEHAVIORAL"
) (
  input  logic [DATA_WIDTH_1-1:0]              a_i,
  input  logic [DATA_WIDTH_2-1:0]              b_i,
  output logic [DATA_WIDTH_1+DATA_WIDTH_2-1:0] p_o
);
  localparam int PW = DATA_WIDTH_1 + DATA_WIDTH_2;

  assign p_o = PW'(a_i) * PW'(b_i);

endmodule

// File: rtl/multiplier_arbiter_rr_arbiter.sv
// Round-robin arbiter; pointer advances only when told a grant was used.
module rr_arbiter
  import multiplier_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt;
  logic [IW-1:0] idx;
  logic          found;
  int            k;

  // Search begins one past the last grant and wraps.
  always_comb begin
    gnt   = '0;
    idx   = ptr_q;
    found = 1'b0;
    k     = 0;
    for (int i = 1; i <= N; i++) begin
      k = int'(ptr_q) + i;
      if (k >= N) k = k - N;
      if (!found && req_i[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IW'(k);
      end
    end
  end

  assign grant_o     = gnt & {N{en_i}};
  assign grant_idx_o = idx;
  assign ptr_d       = advance_i ? idx : ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= IW'(N - 1);
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/multiplier_arbiter.sv
// Round-robin front end sharing one multiplier across N_REQ requesters.
module multiplier_arbiter
  import multiplier_arbiter_pkg::*;
#(
  parameter int    N_REQ        = 4,
  parameter int    DATA_WIDTH_1 = 8,
  parameter int    DATA_WIDTH_2 = 8,
  parameter string ARCHITECTURE = "BEHAVIORAL",
  parameter int    ID_WIDTH     = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en_i,
  input  logic [N_REQ-1:0]                     req_valid_i,
  input  logic [N_REQ*DATA_WIDTH_1-1:0]        req_data1_i,
  input  logic [N_REQ*DATA_WIDTH_2-1:0]        req_data2_i,
  output logic [N_REQ-1:0]                     req_ready_o,
  output logic [N_REQ-1:0]                     result_valid_o,
  output logic [ID_WIDTH-1:0]                  result_id_o,
  output logic [DATA_WIDTH_1+DATA_WIDTH_2-1:0] result_o,
  output logic                                 idle_o,
  output logic [31:0]                          ops_count_o
);
  localparam int RW = res_width(DATA_WIDTH_1, DATA_WIDTH_2);

  if (ID_WIDTH != clog2(N_REQ)) begin : g_bad_id
    $error("ID_WIDTH must equal clog2(N_REQ)");
  end

  logic [N_REQ-1:0]        grant;
  logic [ID_WIDTH-1:0]     gidx;
  logic                    xfer;

  logic                    v1_q, v1_d, v2_q, v2_d;
  logic [DATA_WIDTH_1-1:0] a_q, a_d;
  logic [DATA_WIDTH_2-1:0] b_q, b_d;
  logic [ID_WIDTH-1:0]     id1_q, id1_d, id2_q, id2_d;
  logic [RW-1:0]           p_q, p_d, prod;
  logic [31:0]             ops_q, ops_d;

  // Reset gates the enable so ready drops as soon as rst rises.
  rr_arbiter #(.N(N_REQ), .IW(ID_WIDTH)) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_valid_i),
    .en_i        (en_i & ~rst),
    .advance_i   (xfer),
    .grant_o     (grant),
    .grant_idx_o (gidx)
  );

  assign req_ready_o = grant;
  assign xfer        = |(req_valid_i & grant);

  multiplier #(
    .DATA_WIDTH_1 (DATA_WIDTH_1),
    .DATA_WIDTH_2 (DATA_WIDTH_2),
    .ARCHITECTURE (ARCHITECTURE)
  ) u_mul (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (prod)
  );

  always_comb begin
    v1_d  = xfer;
    a_d   = a_q;
    b_d   = b_q;
    id1_d = id1_q;
    if (xfer) begin
      a_d   = req_data1_i[gidx*DATA_WIDTH_1 +: DATA_WIDTH_1];
      b_d   = req_data2_i[gidx*DATA_WIDTH_2 +: DATA_WIDTH_2];
      id1_d = gidx;
    end
    v2_d  = v1_q;
    p_d   = v1_q ? prod  : p_q;
    id2_d = v1_q ? id1_q : id2_q;
    ops_d = ops_q + {31'b0, xfer};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      id1_q <= '0;
      v2_q  <= 1'b0;
      p_q   <= '0;
      id2_q <= '0;
      ops_q <= '0;
    end else begin
      v1_q  <= v1_d;
      a_q   <= a_d;
      b_q   <= b_d;
      id1_q <= id1_d;
      v2_q  <= v2_d;
      p_q   <= p_d;
      id2_q <= id2_d;
      ops_q <= ops_d;
    end
  end

  assign result_valid_o = v2_q ? (N_REQ'(1) << id2_q) : '0;
  assign result_id_o    = id2_q;
  assign result_o       = p_q;
  assign ops_count_o    = ops_q;
  assign idle_o = ~v1_q & ~v2_q & ~|(req_valid_i & {N_REQ{en_i}});

endmodule
